// File: rtl/eth_pkg.sv
// Shared Ethernet receive definitions: line-code dibits, CRC-32 constants,
// receive FSM state type and a bit-reverse helper.
package eth_pkg;

    // Preamble bytes (0x55) arrive as dibit 01; the SFD (0xD5) ends in dibit 11.
    localparam logic [1:0]  ETH_PREAMBLE_DIBIT = 2'b01;
    localparam logic [1:0]  ETH_SFD_DIBIT      = 2'b11;

    // CRC-32 in normal (MSB-first) notation; the residue is the value left
    // over a frame whose FCS is intact.
    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2,
        ST_DROP     = 2'd3
    } rx_state_e;

    // Converts between reflected (LSB-first) and normal CRC notation.
    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31 - i];
        end
        return r;
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide reflected CRC-32 accumulator. clr_i reloads the initial value,
// en_i folds data_i in LSB first. crc_o is the raw (reflected) register.
module crc32_d8
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    localparam logic [31:0] POLY_REFL = bitrev32(CRC32_POLY);

    logic [31:0] crc_q;
    logic [31:0] crc_d;

    // Next CRC: clear, or eight serial LSB-first steps of the reflected LFSR.
    always_comb begin
        crc_d = crc_q;
        if (clr_i) begin
            crc_d = CRC32_INIT;
        end else if (en_i) begin
            for (int i = 0; i < 8; i++) begin
                if (crc_d[0] ^ data_i[i]) begin
                    crc_d = (crc_d >> 1) ^ POLY_REFL;
                end else begin
                    crc_d = crc_d >> 1;
                end
            end
        end
    end

    // CRC state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= CRC32_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/rmii_rx.sv
// RMII receive framer: strips preamble/SFD, assembles dibits into bytes and
// streams them out one byte-time behind, flagging the last byte and errors.
// Optional FCS checking is built when RMII_RX_CRC_CHECK_EN is defined.
//
// CRS_DV may toggle near the end of a frame while data is still valid, so a
// dibit sampled with crsdv low is parked and only taken as data once crsdv
// is seen high again; two consecutive low samples end the frame and the
// parked dibit is discarded.
module rmii_rx
    import eth_pkg::*;
#(
    parameter int MAX_FRAME_BYTES = 1522
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  eth_rxd,
    input  logic        eth_crsdv,
    input  logic        eth_rxerr,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_last,
    output logic        rx_err,
    output logic [15:0] rx_frame_cnt
);

    localparam int                BCNT_W   = $clog2(MAX_FRAME_BYTES + 2);
    localparam logic [BCNT_W-1:0] BCNT_MAX = BCNT_W'(MAX_FRAME_BYTES);

    // Registered PHY inputs plus the previous sample (crs_p_q low means the
    // dibit in rxd_p_q is parked).
    logic [1:0]  rxd_q, rxd_p_q;
    logic        crs_q, crs_p_q, rxerr_q;

    rx_state_e   state_q, state_d;
    logic [7:0]  sh_q, sh_d;
    logic [1:0]  dcnt_q, dcnt_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_vld_q, hold_vld_d;
    logic        err_flag_q, err_flag_d;

    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        rx_last_q, rx_last_d;
    logic        rx_err_q, rx_err_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;

    logic        byte_done;
    logic [7:0]  byte_val;
    logic        err_any;
    logic        crc_clr;
    logic        crc_en;
    logic        crc_bad;

`ifdef RMII_RX_CRC_CHECK_EN
    logic [31:0] crc_val;

    crc32_d8 u_crc (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (crc_clr),
        .en_i   (crc_en),
        .data_i (byte_val),
        .crc_o  (crc_val)
    );

    assign crc_bad = (bitrev32(crc_val) != CRC32_RESIDUE);
`else
    logic unused_crc;
    assign unused_crc = crc_clr ^ crc_en;
    assign crc_bad    = 1'b0;
`endif

    // Input sampling: control-type inputs are reset, the data dibits are not.
    always_ff @(posedge clk) begin
        if (rst) begin
            crs_q   <= 1'b0;
            crs_p_q <= 1'b0;
            rxerr_q <= 1'b0;
        end else begin
            crs_q   <= eth_crsdv;
            crs_p_q <= crs_q;
            rxerr_q <= eth_rxerr;
        end
        rxd_q   <= eth_rxd;
        rxd_p_q <= rxd_q;
    end

    // Next-state and output decode for the receive FSM.
    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        dcnt_d      = dcnt_q;
        bcnt_d      = bcnt_q;
        hold_d      = hold_q;
        hold_vld_d  = hold_vld_q;
        err_flag_d  = err_flag_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        rx_last_d   = 1'b0;
        rx_err_d    = 1'b0;
        frame_cnt_d = frame_cnt_q;
        byte_done   = 1'b0;
        byte_val    = sh_q;
        err_any     = err_flag_q | rxerr_q;
        crc_clr     = 1'b0;
        crc_en      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (crs_q && (rxd_q == ETH_PREAMBLE_DIBIT)) begin
                    state_d = ST_PREAMBLE;
                end
            end

            ST_PREAMBLE: begin
                if (!crs_q) begin
                    state_d = ST_IDLE;
                end else if (rxd_q == ETH_SFD_DIBIT) begin
                    state_d    = ST_DATA;
                    dcnt_d     = 2'd0;
                    bcnt_d     = '0;
                    hold_vld_d = 1'b0;
                    err_flag_d = 1'b0;
                    crc_clr    = 1'b1;
                end else if (rxd_q != ETH_PREAMBLE_DIBIT) begin
                    state_d = ST_IDLE;
                end
            end

            ST_DATA: begin
                err_flag_d = err_any;
                if (!crs_q && !crs_p_q) begin
                    // End of frame: flush the held byte as the last one.
                    state_d    = ST_IDLE;
                    hold_vld_d = 1'b0;
                    if (hold_vld_q) begin
                        rx_valid_d = 1'b1;
                        rx_last_d  = 1'b1;
                        rx_data_d  = hold_q;
                        rx_err_d   = err_any | (dcnt_q != 2'd0) | crc_bad;
                    end
                end else if (crs_q) begin
                    if (!crs_p_q) begin
                        // Parked dibit and current dibit enter together.
                        sh_d      = {rxd_q, rxd_p_q, sh_q[7:4]};
                        dcnt_d    = dcnt_q + 2'd2;
                        byte_done = dcnt_q[1];
                        byte_val  = dcnt_q[0] ? {rxd_p_q, sh_q[7:2]} : sh_d;
                    end else begin
                        sh_d      = {rxd_q, sh_q[7:2]};
                        dcnt_d    = dcnt_q + 2'd1;
                        byte_done = (dcnt_q == 2'd3);
                        byte_val  = sh_d;
                    end

                    if (byte_done) begin
                        bcnt_d = bcnt_q + BCNT_W'(1);
                        if (bcnt_q == BCNT_MAX) begin
                            // Oversize: close the frame on the held byte.
                            state_d    = ST_DROP;
                            hold_vld_d = 1'b0;
                            rx_valid_d = hold_vld_q;
                            rx_last_d  = hold_vld_q;
                            rx_err_d   = hold_vld_q;
                            rx_data_d  = hold_q;
                        end else begin
                            if (hold_vld_q) begin
                                rx_valid_d = 1'b1;
                                rx_data_d  = hold_q;
                            end
                            hold_d     = byte_val;
                            hold_vld_d = 1'b1;
                            crc_en     = 1'b1;
                        end
                    end
                end
            end

            ST_DROP: begin
                if (!crs_q && !crs_p_q) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        if (rx_last_d && !rx_err_d) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    // Control state and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            dcnt_q      <= 2'd0;
            bcnt_q      <= '0;
            hold_vld_q  <= 1'b0;
            err_flag_q  <= 1'b0;
            rx_data_q   <= 8'd0;
            rx_valid_q  <= 1'b0;
            rx_last_q   <= 1'b0;
            rx_err_q    <= 1'b0;
            frame_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            dcnt_q      <= dcnt_d;
            bcnt_q      <= bcnt_d;
            hold_vld_q  <= hold_vld_d;
            err_flag_q  <= err_flag_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_last_q   <= rx_last_d;
            rx_err_q    <= rx_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Byte assembly data path; qualified by dcnt_q/hold_vld_q so no reset.
    always_ff @(posedge clk) begin
        sh_q   <= sh_d;
        hold_q <= hold_d;
    end

    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign rx_last      = rx_last_q;
    assign rx_err       = rx_err_q;
    assign rx_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_rmii_rx.sv
// Directed bench for rmii_rx (MAX_FRAME_BYTES=64): good frame, bit error,
// PHY error, CRS_DV toggling, empty frame, partial byte, oversize, mid-frame
// reset. Expected bytes and FCS are built by the bench.
module tb_rmii_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  eth_rxd = 2'b00;
    logic        eth_crsdv = 1'b0;
    logic        eth_rxerr = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_last;
    logic        rx_err;
    logic [15:0] rx_frame_cnt;

`ifdef RMII_RX_CRC_CHECK_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    rmii_rx #(.MAX_FRAME_BYTES(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .eth_rxd      (eth_rxd),
        .eth_crsdv    (eth_crsdv),
        .eth_rxerr    (eth_rxerr),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_last      (rx_last),
        .rx_err       (rx_err),
        .rx_frame_cnt (rx_frame_cnt)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec  = 0;
    int n_miss = 0;
    int exp_cnt = 0;

    logic [7:0] tx [0:79];
    int tx_len = 0;

    int pulses = 0, lasts = 0, last_idx = 0, bad_bytes = 0;
    int first_valid_cyc = 0, byte0_cyc = 0;
    logic last_err = 1'b0;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // Output capture, sampled on the falling edge.
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            if (pulses < tx_len && rx_data !== tx[pulses]) bad_bytes++;
            if (pulses == 0) first_valid_cyc = cyc;
            pulses++;
            if (rx_last === 1'b1) begin
                lasts++;
                last_idx = pulses;
                last_err = rx_err;
            end
        end
    end

    // Ethernet FCS: normal-form LFSR over LSB-first bits, reflected and inverted.
    function automatic logic [31:0] fcs_of(input int n);
        logic [31:0] c = 32'hFFFFFFFF;
        logic [31:0] r;
        logic fb;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 8; k++) begin
                fb = c[31] ^ tx[i][k];
                c  = {c[30:0], 1'b0} ^ (fb ? 32'h04C11DB7 : 32'h0);
            end
        end
        for (int k = 0; k < 32; k++) r[k] = c[31 - k];
        return ~r;
    endfunction

    task automatic build_good(input int n, input int seed);
        logic [31:0] f;
        for (int i = 0; i < n; i++) tx[i] = 8'(i * 7 + seed);
        f = fcs_of(n);
        tx[n]     = f[7:0];
        tx[n + 1] = f[15:8];
        tx[n + 2] = f[23:16];
        tx[n + 3] = f[31:24];
        tx_len = n + 4;
    endtask

    task automatic drive(input logic [1:0] d, input logic crs, input logic er);
        @(posedge clk);
        #1;
        eth_rxd   = d;
        eth_crsdv = crs;
        eth_rxerr = er;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(2'b00, 1'b0, 1'b0);
    endtask

    // Sends preamble, SFD and tx[0..tx_len-1]. err_byte pulses eth_rxerr,
    // tail_tog alternates crsdv 0/1 over the final 8 dibits (last one high),
    // extra adds trailing dibits, rst_byte resets the DUT at that byte.
    task automatic send_frame(input int err_byte, input bit tail_tog, input int extra, input int rst_byte);
        logic [7:0] b;
        int nd;
        pulses = 0; lasts = 0; last_idx = 0; bad_bytes = 0;
        last_err = 1'b0; first_valid_cyc = 0;
        for (int i = 0; i < 8; i++) begin
            b = (i == 7) ? 8'hD5 : 8'h55;
            for (int k = 0; k < 4; k++) drive(b[2*k +: 2], 1'b1, 1'b0);
        end
        nd = tx_len * 4;
        for (int i = 0; i < tx_len; i++) begin
            if (i == rst_byte) begin
                @(posedge clk);
                #1;
                rst = 1'b1; eth_crsdv = 1'b0; eth_rxd = 2'b00;
                @(posedge clk);
                #1;
                chk_val("RST.valid", {31'd0, rx_valid}, 0);
                chk_val("RST.last", {31'd0, rx_last}, 0);
                chk_val("RST.err", {31'd0, rx_err}, 0);
                chk_val("RST.data", {24'd0, rx_data}, 0);
                chk_val("RST.cnt", {16'd0, rx_frame_cnt}, 0);
                @(posedge clk);
                #1;
                rst = 1'b0;
                idle(16);
                return;
            end
            b = tx[i];
            for (int k = 0; k < 4; k++) begin
                int j;
                logic crs;
                j = i * 4 + k;
                crs = 1'b1;
                if (tail_tog && j >= nd - 8) crs = (((nd - 1 - j) % 2) == 0);
                drive(b[2*k +: 2], crs, (i == err_byte) && (k == 1));
                if (i == 0 && k == 3) byte0_cyc = cyc;
            end
        end
        for (int k = 0; k < extra; k++) drive(2'b10, 1'b1, 1'b0);
        idle(16);
    endtask

    task automatic check_frame(input string tag, input int exp_pulses, input bit exp_err);
        chk_val({tag, ".pulses"}, pulses, exp_pulses);
        chk_val({tag, ".lasts"}, lasts, (exp_pulses > 0) ? 1 : 0);
        if (exp_pulses > 0) begin
            chk_val({tag, ".last_idx"}, last_idx, exp_pulses);
            chk_val({tag, ".err"}, {31'd0, last_err}, {31'd0, exp_err});
        end
        chk_val({tag, ".data_bad"}, bad_bytes, 0);
        if (!exp_err && exp_pulses > 0) exp_cnt = exp_cnt + 1;
        chk_val({tag, ".cnt"}, {16'd0, rx_frame_cnt}, exp_cnt);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_val("R0.valid", {31'd0, rx_valid}, 0);
        chk_val("R0.last", {31'd0, rx_last}, 0);
        chk_val("R0.err", {31'd0, rx_err}, 0);
        chk_val("R0.data", {24'd0, rx_data}, 0);
        chk_val("R0.cnt", {16'd0, rx_frame_cnt}, 0);
        rst = 1'b0;
        idle(4);

        // Good 60+4 byte frame; byte 0 is sampled one edge after it is driven
        // and appears 5 clocks after that.
        build_good(60, 3);
        send_frame(-1, 1'b0, 0, -1);
        check_frame("A", 64, 1'b0);
        chk_val("A.latency", first_valid_cyc - byte0_cyc, 6);

        // Single payload bit flipped after FCS computed.
        build_good(60, 11);
        tx[10] = tx[10] ^ 8'h08;
        send_frame(-1, 1'b0, 0, -1);
        check_frame("B", 64, CRC_ON);

        // One-clock PHY error mid payload.
        build_good(60, 29);
        send_frame(30, 1'b0, 0, -1);
        check_frame("C", 64, 1'b1);

        // CRS_DV toggling over the last 8 dibits.
        build_good(60, 41);
        send_frame(-1, 1'b1, 0, -1);
        check_frame("D", 64, 1'b0);

        // Preamble + SFD only: no output at all.
        tx_len = 0;
        send_frame(-1, 1'b0, 0, -1);
        check_frame("E", 0, 1'b0);

        // Trailing partial byte (one extra dibit).
        build_good(60, 53);
        send_frame(-1, 1'b0, 1, -1);
        check_frame("P", 64, 1'b1);

        // Oversize: 70 bytes against a 64-byte limit.
        for (int i = 0; i < 70; i++) tx[i] = 8'(255 - i * 3);
        tx_len = 70;
        send_frame(-1, 1'b0, 0, -1);
        check_frame("O", 64, 1'b1);

        // Good frame accepted after oversize drop.
        build_good(60, 77);
        send_frame(-1, 1'b0, 0, -1);
        check_frame("F", 64, 1'b0);

        // Reset at byte 20 aborts the frame and clears the counter.
        build_good(60, 91);
        send_frame(-1, 1'b0, 0, 20);
        chk_val("RST.nolast", lasts, 0);
        exp_cnt = 0;

        build_good(60, 103);
        send_frame(-1, 1'b0, 0, -1);
        check_frame("H", 64, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
